apb_regbank: RTL and testbench
==============================

# apb_regbank

Parametrised APB3 slave register bank that fronts the SPI core. Successor to the fixed zero-wait APB interface, which ties PREADY high and never raises PSLVERR. Adds:
- a bank of NREGS control/status registers;
- programmable wait states (PREADY stretching);
- error responses;
- per-register write strobes to the SPI datapath.

Sits between the APB master and the SPI controller, one instance per SPI channel.

## Interface
Parameters:
- AWIDTH, 4, APB address width; PADDR is a register index.
- DWIDTH, 8, register and data width.
- NREGS, 8, number of implemented registers; 1 ≤ NREGS ≤ 2**AWIDTH.
- WAIT_CYCLES, 0, wait states inserted in every access phase; 0..15.
- RO_MASK, '0, NREGS-bit mask; bit i set means register i is read-only status.
- RST_VAL, '0, NREGS*DWIDTH reset image for writable registers; register i is slice [i*DWIDTH +: DWIDTH].

Ports:
- PCLK  in  1  single clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous and active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  AWIDTH  register index.
- PWDATA  in  DWIDTH  write data.
- PRDATA  out  DWIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- status_i  in  NREGS*DWIDTH  live values returned for read-only registers.
- ctrl_o  out  NREGS*DWIDTH  current contents of writable registers; read-only slices drive 0.
- wr_pulse_o  out  NREGS  one-cycle strobe per register on a committed write.

## Operation
- FSM states and transitions:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), load cnt ← WAIT_CYCLES and latch PADDR/PWRITE/PWDATA; go to ACCESS.
  - ACCESS: if PSEL=0, abort to IDLE with no write and no strobe. Else if cnt≠0, decrement. Else (PREADY=1) complete the transfer and go to IDLE.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (cnt==0).
- Error condition: err = (idx ≥ NREGS) | (PWRITE & RO_MASK[idx]).
- Committed write occurs on the completing edge when PWRITE=1 and err=0:
  - reg[idx] ← PWDATA;
  - wr_pulse_o[idx]=1 for exactly the following cycle.
- A write with err=1 changes no register and raises no strobe.
- Reads:
  - writable register: return the register value;
  - RO register: return status_i slice, sampled in the completing cycle;
  - out-of-range index: return 0 and PSLVERR=1.
- PRDATA and PSLVERR are meaningful only while PREADY=1; both are 0 at all other times.
- Back-to-back transfers: a setup phase is accepted in the cycle after completion (IDLE). Zero dead cycles beyond APB protocol.
- Address/data are used from the setup-phase latch. Changes on PADDR/PWDATA during ACCESS are ignored.

## Timing
- Reset values (PRESET high at a PCLK edge):
  - state IDLE, cnt 0;
  - registers ← RST_VAL;
  - PREADY 0, PSLVERR 0, PRDATA 0, wr_pulse_o 0.
- Reset asserted mid-transfer aborts the transfer: no write, no strobe. PREADY is low the cycle after.
- Latency:
  - access phase lasts WAIT_CYCLES+1 cycles;
  - full transfer lasts WAIT_CYCLES+2 cycles including setup;
  - WAIT_CYCLES=0 gives zero-wait behaviour identical to the old interface.
- ctrl_o updates on the completing edge and is visible the cycle after PREADY.
- wr_pulse_o is registered and coincident with the ctrl_o update.
- PENABLE=1 without a preceding setup (protocol violation) is ignored in IDLE.

## Structure
- Package apb_regbank_pkg holds:
  - state enum (IDLE, ACCESS);
  - CNT_W = 4 localparam;
  - function is_err(idx, write, ro_mask).
- Sub-module apb_wait_ctr: loadable down-counter with zero flag, reused by later APB peripherals.
- Register storage and read mux stay in the top module.

## Test plan
- Reset, then read all NREGS=8 with RST_VAL=0x..0807060504030201 -> PRDATA = i+1 for index i. PSLVERR=0, PREADY high in the first access cycle (WAIT_CYCLES=0).
- WAIT_CYCLES=3: write 0xA5 to index 2 -> PREADY low for 3 access cycles, high on the 4th. ctrl_o[23:16]=0xA5 and wr_pulse_o=0x04 for one cycle after. A read back returns 0xA5.
- RO_MASK=0x80, status_i slice 7 = 0x3C: read index 7 -> 0x3C. Write 0xFF to index 7 -> PSLVERR=1, no strobe, ctrl_o unchanged.
- NREGS=8, AWIDTH=4: read index 9 -> PRDATA=0, PSLVERR=1. Write to index 12 -> PSLVERR=1, no register changes.
- WAIT_CYCLES=2, write to index 1 with PSEL dropped after the first access cycle -> no write, no strobe. A following legal transfer completes normally.
- PRESET pulsed during the wait of a write to index 0 -> register 0 = RST_VAL slice, PREADY=0, no wr_pulse_o.

Source files
------------

// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank and future APB peripherals.
package apb_regbank_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

  localparam int unsigned CNT_W     = 4;
  // Upper bound on register count that is_err can decode.
  localparam int unsigned MAX_IDX_W = 8;
  localparam int unsigned MAX_REGS  = 1 << MAX_IDX_W;

  function automatic logic is_err(input int unsigned         idx,
                                  input logic                write,
                                  input logic [MAX_REGS-1:0] ro_mask,
                                  input int unsigned         nregs);
    if (idx >= nregs) begin
      return 1'b1;
    end
    return write & ro_mask[idx[MAX_IDX_W-1:0]];
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB3 bus bundle between a master and the register bank.
interface apb_regbank_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with zero flag; saturates at zero.
module apb_wait_ctr
  import apb_regbank_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_regbank.sv
// APB3 slave register bank with wait states, error responses and per-register write strobes.
module apb_regbank
  import apb_regbank_pkg::*;
#(
  parameter int unsigned             AWIDTH      = 4,
  parameter int unsigned             DWIDTH      = 8,
  parameter int unsigned             NREGS       = 8,
  parameter int unsigned             WAIT_CYCLES = 0,
  parameter logic [NREGS-1:0]        RO_MASK     = '0,
  parameter logic [NREGS*DWIDTH-1:0] RST_VAL     = '0
) (
  input  logic                    pclk,
  input  logic                    preset,
  apb_regbank_if.slave            bus,
  input  logic [NREGS*DWIDTH-1:0] status_i,
  output logic [NREGS*DWIDTH-1:0] ctrl_o,
  output logic [NREGS-1:0]        wr_pulse_o
);

  localparam logic [MAX_REGS-1:0] RoMaskExt = MAX_REGS'(RO_MASK);
  localparam logic [CNT_W-1:0]    WaitLoad  = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q;
  logic                write_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                setup, dec, cnt_zero;
  logic [CNT_W-1:0]    cnt;
  logic                pready, err, commit;
  logic [DWIDTH-1:0]   rdata;
  logic [DWIDTH-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]    pulse_d, wr_pulse_q;

  // A lone PENABLE in idle is a protocol violation and does not start a transfer.
  assign setup  = (state_q == StIdle) & bus.psel & ~bus.penable;
  assign pready = (state_q == StAccess) & bus.psel & bus.penable & cnt_zero;
  assign err    = is_err(32'(addr_q), write_q, RoMaskExt, NREGS);
  assign commit = pready & write_q & ~err;

  apb_wait_ctr #(
    .W (CNT_W)
  ) u_wait_ctr (
    .clk_i      (pclk),
    .rst_i      (preset),
    .load_i     (setup),
    .load_val_i (WaitLoad),
    .dec_i      (dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (setup) state_d = StAccess;
      end
      StAccess: begin
        if (!bus.psel) begin
          state_d = StIdle;
        end else if (!cnt_zero) begin
          dec = 1'b1;
        end else if (bus.penable) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        addr_q  <= bus.paddr;
        write_q <= bus.pwrite;
        wdata_q <= bus.pwdata;
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    rdata   = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(addr_q) == i) begin
        pulse_d[i] = commit;
        rdata      = RO_MASK[i] ? status_i[i*DWIDTH +: DWIDTH] : regs_q[i];
      end
    end
  end

  // Strobe and register update share the completing edge so they appear together.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= RST_VAL[i*DWIDTH +: DWIDTH];
      end
    end else begin
      wr_pulse_q <= pulse_d;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (pulse_d[i]) regs_q[i] <= wdata_q;
      end
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      ctrl_o[i*DWIDTH +: DWIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign wr_pulse_o  = wr_pulse_q;
  assign bus.pready  = pready;
  assign bus.pslverr = pready & err;
  assign bus.prdata  = (pready & ~write_q) ? rdata : '0;

endmodule

// File: tb/tb_apb_regbank.sv
// Bench for apb_regbank: three instances (0, 3 and 2 wait states) on a shared APB stimulus bus.
module tb_apb_regbank;

  localparam int D0 = 0;  // WAIT_CYCLES=0, no read-only registers
  localparam int D3 = 1;  // WAIT_CYCLES=3, register 7 read-only
  localparam int D2 = 2;  // WAIT_CYCLES=2, register 7 read-only
  localparam logic [63:0] RstImg = 64'h0807060504030201;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       psel [3];
  logic       penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [63:0] status;

  logic [7:0]  rd   [3];
  logic        rdy  [3];
  logic        er   [3];
  logic [7:0]  pls  [3];
  logic [63:0] ctl  [3];

  always #5 pclk = ~pclk;

  apb_regbank_if #(.AWIDTH(4), .DWIDTH(8)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].psel    = psel[g];
    assign bus[g].penable = penable;
    assign bus[g].pwrite  = pwrite;
    assign bus[g].paddr   = paddr;
    assign bus[g].pwdata  = pwdata;
    assign rd[g]  = bus[g].prdata;
    assign rdy[g] = bus[g].pready;
    assign er[g]  = bus[g].pslverr;

    apb_regbank #(
      .AWIDTH      (4),
      .DWIDTH      (8),
      .NREGS       (8),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .RO_MASK     ((g == 0) ? 8'h00 : 8'h80),
      .RST_VAL     (RstImg)
    ) u_dut (
      .pclk       (pclk),
      .preset     (preset),
      .bus        (bus[g]),
      .status_i   (status),
      .ctrl_o     (ctl[g]),
      .wr_pulse_o (pls[g])
    );
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         waits;
    logic [7:0] pulse;
    logic       chk_rd;
  } exp_t;

  typedef struct {
    int         d;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         waits;
    logic [7:0] pulse;
    string      tag;
  } vec_t;

  exp_t sbq [$];
  vec_t vecs [$];
  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input int d, input logic wr, input logic [3:0] a,
                               input logic [7:0] wd, input logic [7:0] rdv, input logic e,
                               input int w, input logic [7:0] p, input string tag);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = a; v.wdata = wd; v.rdata = rdv;
    v.err = e; v.waits = w; v.pulse = p; v.tag = tag;
    return v;
  endfunction

  task automatic xfer(input vec_t v);
    exp_t e;
    int   waits;
    bit   done;
    e.rdata = v.rdata; e.err = v.err; e.waits = v.waits; e.pulse = v.pulse; e.chk_rd = ~v.wr;
    sbq.push_back(e);
    @(posedge pclk); #1;
    psel[v.d] = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata;
    @(posedge pclk); #1;
    // Garbage on address/data during access must be ignored.
    penable = 1'b1; paddr = ~v.addr; pwdata = ~v.wdata;
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      if (rdy[v.d]) done = 1'b1;
      else waits++;
    end
    e = sbq.pop_front();
    if (!done) begin
      nvec++;
      nmis++;
      $display("FAIL %s timeout: pready never rose", v.tag);
    end else begin
      if (e.chk_rd) check({v.tag, " prdata"}, 64'(rd[v.d]), 64'(e.rdata));
      check({v.tag, " pslverr"}, 64'(er[v.d]), 64'(e.err));
      check({v.tag, " waits"}, 64'(waits), 64'(e.waits));
    end
    @(posedge pclk); #1;
    psel[v.d] = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check({v.tag, " wr_pulse"}, 64'(pls[v.d]), 64'(e.pulse));
    check({v.tag, " pready low after"}, 64'(rdy[v.d]), 64'd0);
    @(negedge pclk);
    check({v.tag, " wr_pulse cleared"}, 64'(pls[v.d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    status  = {8'h3C, 56'hEEEEEEEEEEEEEE};
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset pready d%0d", i), 64'(rdy[i]), 64'd0);
      check($sformatf("reset pslverr d%0d", i), 64'(er[i]), 64'd0);
      check($sformatf("reset prdata d%0d", i), 64'(rd[i]), 64'd0);
      check($sformatf("reset wr_pulse d%0d", i), 64'(pls[i]), 64'd0);
    end
    check("reset ctrl d0", ctl[D0], 64'h0807060504030201);
    check("reset ctrl d3 ro slice zero", ctl[D3], 64'h0007060504030201);

    for (int i = 0; i < 8; i++)
      vecs.push_back(mkv(D0, 1'b0, 4'(i), 8'h00, 8'(i + 1), 1'b0, 0, 8'h00,
                         $sformatf("d0 read %0d", i)));
    vecs.push_back(mkv(D3, 1'b1, 4'd2,  8'hA5, 8'h00, 1'b0, 3, 8'h04, "d3 write 2"));
    vecs.push_back(mkv(D3, 1'b0, 4'd2,  8'h00, 8'hA5, 1'b0, 3, 8'h00, "d3 read 2"));
    vecs.push_back(mkv(D3, 1'b0, 4'd7,  8'h00, 8'h3C, 1'b0, 3, 8'h00, "d3 read ro 7"));
    vecs.push_back(mkv(D3, 1'b1, 4'd7,  8'hFF, 8'h00, 1'b1, 3, 8'h00, "d3 write ro 7"));
    vecs.push_back(mkv(D3, 1'b0, 4'd9,  8'h00, 8'h00, 1'b1, 3, 8'h00, "d3 read oor 9"));
    vecs.push_back(mkv(D3, 1'b1, 4'd12, 8'h5A, 8'h00, 1'b1, 3, 8'h00, "d3 write oor 12"));
    vecs.push_back(mkv(D3, 1'b0, 4'd0,  8'h00, 8'h01, 1'b0, 3, 8'h00, "d3 read 0"));
    vecs.push_back(mkv(D0, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1, 0, 8'h00, "d0 read oor 15"));
    vecs.push_back(mkv(D0, 1'b1, 4'd12, 8'hC3, 8'h00, 1'b1, 0, 8'h00, "d0 write oor 12"));
    foreach (vecs[i]) xfer(vecs[i]);

    check("d3 ctrl after writes", ctl[D3], 64'h0007060504A50201);
    check("d0 ctrl unchanged", ctl[D0], 64'h0807060504030201);

    // Back-to-back on d0: write 3 then read 3 with no idle cycle between.
    @(posedge pclk); #1;
    psel[D0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd3; pwdata = 8'h33;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    check("b2b write pready", 64'(rdy[D0]), 64'd1);
    @(posedge pclk); #1;
    penable = 1'b0; pwrite = 1'b0; paddr = 4'd3;
    @(negedge pclk);
    check("b2b write pulse", 64'(pls[D0]), 64'h08);
    check("b2b setup pready low", 64'(rdy[D0]), 64'd0);
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    check("b2b read pready", 64'(rdy[D0]), 64'd1);
    check("b2b read prdata", 64'(rd[D0]), 64'h33);
    @(posedge pclk); #1;
    psel[D0] = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("b2b ctrl d0", ctl[D0], 64'h0807060533030201);

    // Abort on d2: PSEL drops after the first access cycle.
    @(posedge pclk); #1;
    psel[D2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 8'h77;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    check("abort access1 pready", 64'(rdy[D2]), 64'd0);
    @(posedge pclk); #1;
    psel[D2] = 1'b0; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      check($sformatf("abort pready c%0d", k), 64'(rdy[D2]), 64'd0);
      check($sformatf("abort pulse c%0d", k), 64'(pls[D2]), 64'd0);
    end
    check("abort ctrl slice1", 64'(ctl[D2][15:8]), 64'h02);
    xfer(mkv(D2, 1'b0, 4'd1, 8'h00, 8'h02, 1'b0, 2, 8'h00, "d2 read 1 after abort"));
    xfer(mkv(D2, 1'b1, 4'd1, 8'h5A, 8'h00, 1'b0, 2, 8'h02, "d2 write 1 after abort"));
    check("d2 ctrl slice1", 64'(ctl[D2][15:8]), 64'h5A);

    // Reset during the wait of a d3 write to register 0.
    @(posedge pclk); #1;
    psel[D3] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 8'h99;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    check("rst-mid waiting pready", 64'(rdy[D3]), 64'd0);
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0;
    @(negedge pclk);
    check("rst-mid pready after", 64'(rdy[D3]), 64'd0);
    check("rst-mid pulse after", 64'(pls[D3]), 64'd0);
    @(negedge pclk);
    check("stray penable pready", 64'(rdy[D3]), 64'd0);
    check("stray penable pulse", 64'(pls[D3]), 64'd0);
    @(posedge pclk); #1;
    psel[D3] = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("rst-mid ctrl d3", ctl[D3], 64'h0007060504030201);
    check("rst ctrl d0", ctl[D0], 64'h0807060504030201);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
